lockstep_checker: RTL and testbench
===================================

LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WARMUP, default 2: number of compare-eligible cycles ignored after start, to cover pipeline fill.
REQ-003 Parameter MAX_CYCLES, default 80: number of compared cycles after which the run passes; 0 means the run never passes.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 clr  input  1  synchronous active-high reset.
REQ-006 en  input  1  run enable; a rising level in IDLE starts a run.
REQ-007 pc_a, inst_a, ealu_a, malu_a, wdi_a  input  32 each  trace from CPU A.
REQ-008 pc_b, inst_b, ealu_b, malu_b, wdi_b  input  32 each  trace from CPU B.
REQ-009 state  output  3  current FSM state encoding.
REQ-010 mismatch  output  1  sticky fail flag.
REQ-011 passed  output  1  sticky pass flag.
REQ-012 cycle_cnt  output  16  number of compared cycles.
REQ-013 fail_cycle  output  16  value of cycle_cnt at the first mismatch.
REQ-014 fail_mask  output  5  differing fields at the first mismatch: bit 0 = pc, 1 = inst, 2 = ealu, 3 = malu, 4 = wdi.
REQ-015 fail_pc_a, fail_pc_b  output  32 each  pc values captured at the first mismatch.

Function
REQ-016 FSM states SHALL be IDLE, WARMUP, COMPARE, FAIL and PASS.
REQ-017 IDLE -> WARMUP on an edge with en=1; cycle_cnt and the warmup counter clear on that edge.
REQ-018 WARMUP SHALL last exactly WARMUP edges, with no comparison, then move to COMPARE; if WARMUP=0, IDLE goes directly to COMPARE.
REQ-019 COMPARE SHALL sample both traces on each edge and compute a 5-bit difference mask.
REQ-020 If the mask is nonzero: move to FAIL; mismatch=1; fail_mask=mask; fail_cycle=cycle_cnt (pre-increment); fail_pc_a/fail_pc_b = pc_a/pc_b.
REQ-021 If the mask is zero: increment cycle_cnt; when the incremented value equals MAX_CYCLES (MAX_CYCLES>0), move to PASS and set passed=1.
REQ-022 A mismatch and the final compared cycle on the same edge SHALL resolve to FAIL.
REQ-023 cycle_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-024 en=0 on an edge in WARMUP or COMPARE SHALL return the FSM to IDLE; counters hold their values.
REQ-025 FAIL and PASS SHALL be terminal: they are left only via clr, and en is ignored there.
REQ-026 Response latency SHALL be one edge: flags and capture registers are valid after the edge that sampled the differing or final data.
REQ-027 fail_* registers SHALL update only on the FAIL transition.

Reset
REQ-028 While clr=1 at an edge, all outputs SHALL clear: state=IDLE, mismatch=0, passed=0, cycle_cnt=0, fail_cycle=0, fail_mask=0, fail_pc_a=0, fail_pc_b=0.
REQ-029 clr SHALL take priority over every other event, including mid-run and the FAIL edge itself.

Configuration
REQ-030 With macro LOCKSTEP_HISTORY_EN defined, the block SHALL contain a 4-entry circular buffer of pc_a values, written on every COMPARE edge.
REQ-031 With LOCKSTEP_HISTORY_EN defined, the buffer SHALL freeze on entry to FAIL and be read combinationally via hist_idx (input, 2 bits; 0 = newest) and hist_pc (output, 32 bits).
REQ-032 With LOCKSTEP_HISTORY_EN defined, clr SHALL zero the buffer.
REQ-033 Without LOCKSTEP_HISTORY_EN, the hist_idx/hist_pc ports and the buffer SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package lockstep_pkg SHALL hold the state enum, the field-index constants (FLD_PC=0 through FLD_WDI=4), the data width DW=32 and the counter width CW=16.
REQ-035 Sub-module lockstep_history SHALL implement the history buffer and SHALL be instantiated only under LOCKSTEP_HISTORY_EN.

Verification
REQ-036 Identical traces, WARMUP=2, MAX_CYCLES=80, en=1 -> passed=1 exactly 82 edges after start, cycle_cnt=80, mismatch=0.
REQ-037 ealu_b differs (32'h5 vs 32'h4) on compare cycle 10 -> mismatch=1, fail_cycle=10, fail_mask=5'b00100, and cycle_cnt stays at 10 thereafter.
REQ-038 Traces differ only during the 2 warmup edges -> no FAIL; the run passes normally.
REQ-039 pc and wdi both differ on the final (80th) compared cycle -> FAIL with fail_mask=5'b10001; passed stays 0.
REQ-040 clr pulsed at compare cycle 30, then en held high -> all outputs zero on the clr edge, and a new run restarts from WARMUP.
REQ-041 With LOCKSTEP_HISTORY_EN, pc_a sequence 0x00, 0x04, 0x08, 0x0C, 0x10 with a mismatch at 0x10 -> hist_pc for hist_idx 0..3 = 0x10, 0x0C, 0x08, 0x04.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared types and constants for the dual-CPU lockstep trace checker.
package lockstep_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned NFLD = 5;

  localparam int unsigned FLD_PC   = 0;
  localparam int unsigned FLD_INST = 1;
  localparam int unsigned FLD_EALU = 2;
  localparam int unsigned FLD_MALU = 3;
  localparam int unsigned FLD_WDI  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_FAIL    = 3'd3,
    ST_PASS    = 3'd4
  } state_e;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic [DW-1:0] ealu;
    logic [DW-1:0] malu;
    logic [DW-1:0] wdi;
  } trace_t;

  // One bit per trace field that differs between the two CPUs.
  function automatic logic [NFLD-1:0] diff_mask(input trace_t a, input trace_t b);
    logic [NFLD-1:0] m;
    m           = '0;
    m[FLD_PC]   = (a.pc   != b.pc);
    m[FLD_INST] = (a.inst != b.inst);
    m[FLD_EALU] = (a.ealu != b.ealu);
    m[FLD_MALU] = (a.malu != b.malu);
    m[FLD_WDI]  = (a.wdi  != b.wdi);
    return m;
  endfunction

endpackage

// File: rtl/lockstep_history.sv
// Four-entry circular buffer of recent pc values; read index 0 is the newest entry.
module lockstep_history
  import lockstep_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic [1:0]    rd_idx,
  output logic [DW-1:0] rd_data_c
);

  logic [DW-1:0] mem [4];
  logic [1:0]    wptr;
  logic [1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wptr <= '0;
    end else if (wr_en) begin
      mem[wptr] <= din;
      wptr      <= wptr + 2'd1;
    end
  end

  // wptr points at the next free slot, so the newest entry sits one behind it.
  assign rd_ptr    = wptr - 2'd1 - rd_idx;
  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/lockstep_checker.sv
// Compares the retirement traces of two lockstepped CPUs and latches the first divergence.
// Optional pc history buffer is built when LOCKSTEP_HISTORY_EN is defined.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int unsigned WARMUP     = 2,
  parameter int unsigned MAX_CYCLES = 80
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   pc_a,
  input  logic [DW-1:0]   inst_a,
  input  logic [DW-1:0]   ealu_a,
  input  logic [DW-1:0]   malu_a,
  input  logic [DW-1:0]   wdi_a,
  input  logic [DW-1:0]   pc_b,
  input  logic [DW-1:0]   inst_b,
  input  logic [DW-1:0]   ealu_b,
  input  logic [DW-1:0]   malu_b,
  input  logic [DW-1:0]   wdi_b,
  output logic [2:0]      state,
  output logic            mismatch,
  output logic            passed,
  output logic [CW-1:0]   cycle_cnt,
  output logic [CW-1:0]   fail_cycle,
  output logic [NFLD-1:0] fail_mask,
  output logic [DW-1:0]   fail_pc_a,
  output logic [DW-1:0]   fail_pc_b
`ifdef LOCKSTEP_HISTORY_EN
  ,
  input  logic [1:0]      hist_idx,
  output logic [DW-1:0]   hist_pc
`endif
);

  localparam logic [CW-1:0] WARM_LAST = (WARMUP == 0) ? '0 : CW'(WARMUP - 1);
  localparam bit            PASS_EN   = (MAX_CYCLES > 0) && (MAX_CYCLES <= 65535);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_CYCLES);

  state_e          state_q;
  state_e          state_nxt;
  logic [CW-1:0]   warm_cnt;
  logic [CW-1:0]   cnt_next;
  logic [NFLD-1:0] mask;
  trace_t          trace_a;
  trace_t          trace_b;

  logic cnt_clr;
  logic cnt_inc;
  logic warm_clr;
  logic warm_inc;
  logic capture;
  logic pass_set;

  assign trace_a = '{pc: pc_a, inst: inst_a, ealu: ealu_a, malu: malu_a, wdi: wdi_a};
  assign trace_b = '{pc: pc_b, inst: inst_b, ealu: ealu_b, malu: malu_b, wdi: wdi_b};
  assign mask    = diff_mask(trace_a, trace_b);

  // Saturating increment: the count never wraps back to zero.
  assign cnt_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CW'(1);

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    warm_clr  = 1'b0;
    warm_inc  = 1'b0;
    capture   = 1'b0;
    pass_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          cnt_clr   = 1'b1;
          warm_clr  = 1'b1;
          state_nxt = (WARMUP == 0) ? ST_COMPARE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          warm_inc = 1'b1;
          if (warm_cnt == WARM_LAST) state_nxt = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // A difference on the final compared cycle still fails: mask is tested first.
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (mask != '0) begin
          capture   = 1'b1;
          state_nxt = ST_FAIL;
        end else begin
          cnt_inc = 1'b1;
          if (PASS_EN && (cnt_next == MAX_C)) begin
            pass_set  = 1'b1;
            state_nxt = ST_PASS;
          end
        end
      end
      default: state_nxt = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_cnt  <= '0;
      warm_cnt   <= '0;
      mismatch   <= 1'b0;
      passed     <= 1'b0;
      fail_cycle <= '0;
      fail_mask  <= '0;
      fail_pc_a  <= '0;
      fail_pc_b  <= '0;
    end else begin
      if (cnt_clr)      cycle_cnt <= '0;
      else if (cnt_inc) cycle_cnt <= cnt_next;
      if (warm_clr)      warm_cnt <= '0;
      else if (warm_inc) warm_cnt <= warm_cnt + CW'(1);
      if (capture) begin
        mismatch   <= 1'b1;
        fail_mask  <= mask;
        fail_cycle <= cycle_cnt;
        fail_pc_a  <= pc_a;
        fail_pc_b  <= pc_b;
      end
      if (pass_set) passed <= 1'b1;
    end
  end

`ifdef LOCKSTEP_HISTORY_EN
  // Writes stop once COMPARE is left, so the buffer freezes on entry to FAIL.
  lockstep_history u_history (
    .clk      (clk),
    .clr      (clr),
    .wr_en    ((state_q == ST_COMPARE) && en),
    .din      (pc_a),
    .rd_idx   (hist_idx),
    .rd_data_c(hist_pc)
  );
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Scoreboard bench for lockstep_checker: driver pushes model predictions, monitor compares.
module tb_lockstep_checker;
  import lockstep_pkg::*;

  localparam int unsigned WU = 2;
  localparam int unsigned MC = 80;

  logic        clk = 1'b0;
  logic        clr, en;
  logic [31:0] pc_a, inst_a, ealu_a, malu_a, wdi_a;
  logic [31:0] pc_b, inst_b, ealu_b, malu_b, wdi_b;
  logic [2:0]  state;
  logic        mismatch, passed;
  logic [15:0] cycle_cnt, fail_cycle;
  logic [4:0]  fail_mask;
  logic [31:0] fail_pc_a, fail_pc_b;
`ifdef LOCKSTEP_HISTORY_EN
  logic [1:0]  hist_idx;
  logic [31:0] hist_pc;
`endif

  lockstep_checker #(.WARMUP(WU), .MAX_CYCLES(MC)) dut (
    .clk(clk), .clr(clr), .en(en),
    .pc_a(pc_a), .inst_a(inst_a), .ealu_a(ealu_a), .malu_a(malu_a), .wdi_a(wdi_a),
    .pc_b(pc_b), .inst_b(inst_b), .ealu_b(ealu_b), .malu_b(malu_b), .wdi_b(wdi_b),
    .state(state), .mismatch(mismatch), .passed(passed),
    .cycle_cnt(cycle_cnt), .fail_cycle(fail_cycle), .fail_mask(fail_mask),
    .fail_pc_a(fail_pc_a), .fail_pc_b(fail_pc_b)
`ifdef LOCKSTEP_HISTORY_EN
    , .hist_idx(hist_idx), .hist_pc(hist_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        mm;
    logic        ps;
    logic [15:0] cc;
    logic [15:0] fc;
    logic [4:0]  fm;
    logic [31:0] fpa;
    logic [31:0] fpb;
    logic [31:0] hpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: a run is "active" after start, spends warm_left edges
  // warming up, then counts clean compares until it passes or a field differs.
  bit          m_active, m_failed, m_passed;
  int          m_warm_left, m_cnt;
  logic [15:0] m_fc;
  logic [4:0]  m_fm;
  logic [31:0] m_fpa, m_fpb;
  logic [31:0] m_hist[$];
  int          hidx_force = -1;
  logic [1:0]  cur_hidx;

  function void model_step();
    logic [4:0] d;
    d = {wdi_a != wdi_b, malu_a != malu_b, ealu_a != ealu_b, inst_a != inst_b, pc_a != pc_b};
    if (clr) begin
      m_active = 0; m_failed = 0; m_passed = 0; m_warm_left = 0; m_cnt = 0;
      m_fc = 0; m_fm = 0; m_fpa = 0; m_fpb = 0;
      m_hist = '{32'h0, 32'h0, 32'h0, 32'h0};
    end else if (m_failed || m_passed) begin
      // terminal until cleared
    end else if (!m_active) begin
      if (en) begin
        m_active = 1; m_cnt = 0; m_warm_left = WU;
      end
    end else if (!en) begin
      m_active = 0;
    end else if (m_warm_left > 0) begin
      m_warm_left--;
    end else begin
      m_hist.push_front(pc_a);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      if (d != 0) begin
        m_failed = 1; m_fm = d; m_fc = 16'(m_cnt); m_fpa = pc_a; m_fpb = pc_b;
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (MC > 0 && m_cnt == int'(MC)) m_passed = 1;
      end
    end
  endfunction

  function exp_t model_snapshot();
    exp_t e;
    if (m_failed)            e.st = ST_FAIL;
    else if (m_passed)       e.st = ST_PASS;
    else if (!m_active)      e.st = ST_IDLE;
    else if (m_warm_left > 0) e.st = ST_WARMUP;
    else                     e.st = ST_COMPARE;
    e.mm  = m_failed;
    e.ps  = m_passed;
    e.cc  = 16'(m_cnt);
    e.fc  = m_fc;
    e.fm  = m_fm;
    e.fpa = m_fpa;
    e.fpb = m_fpb;
    e.hpc = m_hist[cur_hidx];
    return e;
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endfunction

  // One clock of stimulus: random identical traces, then fields in dm made to differ.
  task automatic cyc(input bit c, input bit e, input logic [4:0] dm,
                     input bit fp, input logic [31:0] pv);
    @(negedge clk);
    clr = c; en = e;
    pc_a = fp ? pv : $urandom(); inst_a = $urandom(); ealu_a = $urandom();
    malu_a = $urandom(); wdi_a = $urandom();
    pc_b = pc_a; inst_b = inst_a; ealu_b = ealu_a; malu_b = malu_a; wdi_b = wdi_a;
    if (dm[FLD_PC])   pc_b   = pc_a   ^ ($urandom() | 32'h1);
    if (dm[FLD_INST]) inst_b = inst_a ^ ($urandom() | 32'h1);
    if (dm[FLD_EALU]) begin ealu_a = 32'h5; ealu_b = 32'h4; end
    if (dm[FLD_MALU]) malu_b = malu_a ^ ($urandom() | 32'h1);
    if (dm[FLD_WDI])  wdi_b  = wdi_a  ^ ($urandom() | 32'h1);
    cur_hidx = (hidx_force >= 0) ? 2'(hidx_force) : 2'($urandom_range(0, 3));
`ifdef LOCKSTEP_HISTORY_EN
    hist_idx = cur_hidx;
`endif
    model_step();
    exp_q.push_back(model_snapshot());
  endtask

  // Monitor: the DUT presents a full status word after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",      32'(state),      32'(e.st));
        chk("mismatch",   32'(mismatch),   32'(e.mm));
        chk("passed",     32'(passed),     32'(e.ps));
        chk("cycle_cnt",  32'(cycle_cnt),  32'(e.cc));
        chk("fail_cycle", 32'(fail_cycle), 32'(e.fc));
        chk("fail_mask",  32'(fail_mask),  32'(e.fm));
        chk("fail_pc_a",  fail_pc_a,       e.fpa);
        chk("fail_pc_b",  fail_pc_b,       e.fpb);
`ifdef LOCKSTEP_HISTORY_EN
        chk("hist_pc",    hist_pc,         e.hpc);
`endif
      end
    end
  end

  initial begin
    logic [4:0] dm;
    bit c, e;
    m_hist = '{32'h0, 32'h0, 32'h0, 32'h0};
    cur_hidx = 2'd0;

    cyc(1, 0, 5'b0, 0, 0);
    cyc(1, 1, 5'b0, 0, 0);
    cyc(0, 0, 5'b0, 0, 0);

    // Identical traces: pass 82 edges after the start edge.
    for (int j = 0; j < 86; j++) cyc(0, 1, 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // ealu difference on compare cycle 10, then hold.
    for (int j = 0; j < 20; j++) cyc(0, 1, (j == 13) ? 5'b00100 : 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // Differences only while warming up.
    for (int j = 0; j < 86; j++) cyc(0, 1, (j == 1 || j == 2) ? 5'b11111 : 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // pc and wdi differ on the 80th compared cycle.
    for (int j = 0; j < 86; j++) cyc(0, 1, (j == 82) ? 5'b10001 : 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // clr mid-run at compare cycle 30 with en held high, then a fresh run.
    for (int j = 0; j < 120; j++) cyc((j == 33) ? 1'b1 : 1'b0, 1, 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // en dropped during warmup and compare.
    for (int j = 0; j < 40; j++) cyc(0, !(j == 2 || j == 20 || j == 21), 5'b0, 0, 0);
    cyc(1, 0, 5'b0, 0, 0);

    // pc sequence 0x00..0x10 over compare cycles with a mismatch at 0x10.
    for (int j = 0; j < 8; j++)
      cyc(0, 1, (j == 7) ? 5'b00010 : 5'b0, (j >= 3), 32'((j - 3) * 4));
    for (int k = 0; k < 4; k++) begin
      hidx_force = k;
      cyc(0, 1, 5'b0, 0, 0);
    end
    hidx_force = -1;
    cyc(1, 0, 5'b0, 0, 0);

    // Randomised runs with occasional clr, en drops and single-cycle differences.
    for (int j = 0; j < 1500; j++) begin
      c  = ($urandom_range(0, 119) == 0);
      e  = ($urandom_range(0, 39) != 0);
      dm = ($urandom_range(0, 99) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      cyc(c, e, dm, 0, 0);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
